// File: rtl/rni_axi_wr_ctl.sv
// Write-path sequencer for the RNI AXI slave port: queues AW words, caps outstanding writes,
// issues one core request per burst and streams its W beats with a local beat index and last flag.

`ifndef AXI4_AW_WIDTH
`define AXI4_AW_WIDTH 48
`endif
`ifndef AXI4_AWLEN_RANGE
`define AXI4_AWLEN_RANGE 15:8
`endif
`ifndef AXI4_W_WIDTH
`define AXI4_W_WIDTH 37
`endif
`ifndef AXI4_WLAST_RANGE
`define AXI4_WLAST_RANGE 36:36
`endif

module rni_axi_wr_ctl #(
    parameter int AWQ_DEPTH = 4,
    parameter int AWQ_PTR_W = 2,
    parameter int MAX_OS    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [`AXI4_AW_WIDTH-1:0] AW_CH_S0,
    input  logic                      AWVALID0,
    output logic                      AWREADY0,
    input  logic [`AXI4_W_WIDTH-1:0]  W_CH_S0,
    input  logic                      WVALID0,
    output logic                      WREADY0,
    output logic                      wr_req_valid_o,
    input  logic                      wr_req_ready_i,
    output logic [`AXI4_AW_WIDTH-1:0] wr_req_aw_o,
    output logic                      wr_dat_valid_o,
    input  logic                      wr_dat_ready_i,
    output logic [`AXI4_W_WIDTH-1:0]  wr_dat_w_o,
    output logic [7:0]                wr_dat_idx_o,
    output logic                      wr_dat_last_o,
    input  logic                      b_done_i,
    output logic [7:0]                os_cnt_o,
    output logic                      err_wlast_o
);

    localparam logic [7:0]         MAX_OS_C = 8'(MAX_OS);
    localparam logic [AWQ_PTR_W:0] DEPTH_C  = (AWQ_PTR_W+1)'(AWQ_DEPTH);
    localparam logic [AWQ_PTR_W:0] CNT_ONE  = {{AWQ_PTR_W{1'b0}}, 1'b1};
    localparam logic [AWQ_PTR_W:0] CNT_ZERO = {(AWQ_PTR_W+1){1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    state_e                      state_r;
    state_e                      state_s;
    logic [`AXI4_AW_WIDTH-1:0]   mem_r [AWQ_DEPTH];
    logic [AWQ_PTR_W-1:0]        wr_ptr_r;
    logic [AWQ_PTR_W-1:0]        rd_ptr_r;
    logic [AWQ_PTR_W:0]          cnt_r;
    logic [7:0]                  os_cnt_r;
    logic [7:0]                  beat_cnt_r;
    logic                        err_r;
    logic                        rdy_en_r;

    logic                        push_s;
    logic                        pop_s;
    logic                        dat_hs_s;
    logic                        last_s;
    logic                        os_dec_s;
    logic                        beat_clr_s;
    logic                        beat_inc_s;
    logic                        err_set_s;
    logic [`AXI4_AW_WIDTH-1:0]   head_s;

    // Handshake qualifiers; readiness is held off for one cycle after reset release.
    assign AWREADY0 = rdy_en_r && (cnt_r != DEPTH_C) && (os_cnt_r < MAX_OS_C);
    assign push_s   = AWVALID0 && AWREADY0;
    assign head_s   = mem_r[rd_ptr_r];
    assign last_s   = (beat_cnt_r == head_s[`AXI4_AWLEN_RANGE]);
    assign dat_hs_s = (state_r == ST_DATA) && WVALID0 && wr_dat_ready_i;
    assign os_dec_s = b_done_i && (os_cnt_r != 8'd0);

    assign wr_req_aw_o   = (state_r == ST_REQ)  ? head_s     : {`AXI4_AW_WIDTH{1'b0}};
    assign wr_dat_w_o    = (state_r == ST_DATA) ? W_CH_S0    : {`AXI4_W_WIDTH{1'b0}};
    assign wr_dat_idx_o  = (state_r == ST_DATA) ? beat_cnt_r : 8'd0;
    assign wr_dat_last_o = (state_r == ST_DATA) && last_s;
    assign os_cnt_o      = os_cnt_r;
    assign err_wlast_o   = err_r;

    // Next-state and per-state output decode.
    always_comb begin
        state_s        = state_r;
        wr_req_valid_o = 1'b0;
        wr_dat_valid_o = 1'b0;
        WREADY0        = 1'b0;
        pop_s          = 1'b0;
        beat_clr_s     = 1'b0;
        beat_inc_s     = 1'b0;
        err_set_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cnt_r != CNT_ZERO) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                wr_req_valid_o = 1'b1;
                if (wr_req_ready_i) begin
                    beat_clr_s = 1'b1;
                    state_s    = ST_DATA;
                end else begin
                    state_s    = ST_REQ;
                end
            end
            ST_DATA: begin
                wr_dat_valid_o = WVALID0;
                WREADY0        = wr_dat_ready_i;
                if (dat_hs_s) begin
                    err_set_s = (W_CH_S0[`AXI4_WLAST_RANGE] != last_s);
                    if (last_s) begin
                        pop_s = 1'b1;
                        // Entry left behind after the pop, counting one pushed this cycle.
                        if ((cnt_r != CNT_ONE) || push_s) begin
                            state_s = ST_REQ;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        beat_inc_s = 1'b1;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and post-reset ready enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            rdy_en_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            rdy_en_r <= 1'b1;
        end
    end

    // AW queue storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < AWQ_DEPTH; i++) begin
                mem_r[i] <= {`AXI4_AW_WIDTH{1'b0}};
            end
            wr_ptr_r <= {AWQ_PTR_W{1'b0}};
            rd_ptr_r <= {AWQ_PTR_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= AW_CH_S0;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
        end
    end

    // Queue occupancy and outstanding-write counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= CNT_ZERO;
            os_cnt_r <= 8'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + 1'b1;
                2'b01:   cnt_r <= cnt_r - 1'b1;
                default: cnt_r <= cnt_r;
            endcase
            case ({push_s, os_dec_s})
                2'b10:   os_cnt_r <= os_cnt_r + 8'd1;
                2'b01:   os_cnt_r <= os_cnt_r - 8'd1;
                default: os_cnt_r <= os_cnt_r;
            endcase
        end
    end

    // Beat index within the active burst and sticky WLAST disagreement flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_r <= 8'd0;
            err_r      <= 1'b0;
        end else begin
            if (beat_clr_s) begin
                beat_cnt_r <= 8'd0;
            end else if (beat_inc_s) begin
                beat_cnt_r <= beat_cnt_r + 8'd1;
            end
            if (err_set_s) begin
                err_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rni_axi_wr_ctl.sv
// Self-checking bench for rni_axi_wr_ctl: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
`timescale 1ns/1ps

`ifndef AXI4_AW_WIDTH
`define AXI4_AW_WIDTH 48
`endif
`ifndef AXI4_AWLEN_RANGE
`define AXI4_AWLEN_RANGE 15:8
`endif
`ifndef AXI4_W_WIDTH
`define AXI4_W_WIDTH 37
`endif
`ifndef AXI4_WLAST_RANGE
`define AXI4_WLAST_RANGE 36:36
`endif

module tb_rni_axi_wr_ctl;

    localparam int AWW = `AXI4_AW_WIDTH;
    localparam int WW  = `AXI4_W_WIDTH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [AWW-1:0]  aw_ch;
    logic            awvalid, awready;
    logic [WW-1:0]   w_ch;
    logic            wvalid, wready;
    logic            req_valid, req_ready;
    logic [AWW-1:0]  req_aw;
    logic            dat_valid, dat_ready;
    logic [WW-1:0]   dat_w;
    logic [7:0]      dat_idx;
    logic            dat_last;
    logic            b_done;
    logic [7:0]      os_cnt;
    logic            err_wlast;

    rni_axi_wr_ctl dut (
        .clk(clk), .rst_n(rst_n),
        .AW_CH_S0(aw_ch), .AWVALID0(awvalid), .AWREADY0(awready),
        .W_CH_S0(w_ch), .WVALID0(wvalid), .WREADY0(wready),
        .wr_req_valid_o(req_valid), .wr_req_ready_i(req_ready), .wr_req_aw_o(req_aw),
        .wr_dat_valid_o(dat_valid), .wr_dat_ready_i(dat_ready), .wr_dat_w_o(dat_w),
        .wr_dat_idx_o(dat_idx), .wr_dat_last_o(dat_last),
        .b_done_i(b_done), .os_cnt_o(os_cnt), .err_wlast_o(err_wlast)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AWW-1:0] mk_aw(input logic [7:0] len, input logic [31:0] addr);
        return {addr, len, 8'h5a};
    endfunction

    function automatic logic [WW-1:0] mk_w(input logic wl, input logic [31:0] data);
        return {wl, 4'hf, data};
    endfunction

    // Holds reset, checks the reset state, releases and checks the quiet first cycle.
    task automatic do_reset();
        rst_n = 1'b0; awvalid = 0; wvalid = 0; req_ready = 0; dat_ready = 0; b_done = 0;
        aw_ch = '0; w_ch = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_awready", awready, 0);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_dat_valid", dat_valid, 0);
        chk("rst_os", os_cnt, 0);
        chk("rst_err", err_wlast, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("first_cycle_awready", awready, 0);
        chk("first_cycle_wready", wready, 0);
    endtask

    typedef struct {
        bit awv; logic [7:0] len; bit wv; bit wl; bit rqr; bit dr; bit bd;
        bit e_awr; bit e_rqv; bit e_dat; logic [7:0] e_idx; bit e_last; logic [7:0] e_os; bit e_err;
    } vec_t;
    vec_t tv[$];

    // Reference model state for the randomized section.
    logic [AWW-1:0] mq[$];
    int  m_os, m_beat, n_hs;
    bit  m_req, m_dat, m_err, m_last, e_awr, aw_hs;
    int  old_sz;
    logic [7:0] hl;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            awv len wv wl rqr dr bd | awr rqv dat idx last os err
        // single beat, AWLEN=0, core always ready
        tv.push_back('{1, 0, 1, 1, 1, 1, 0,  1, 0, 0, 0, 0, 0, 0});
        tv.push_back('{0, 0, 1, 1, 1, 1, 0,  1, 0, 0, 0, 0, 1, 0});
        tv.push_back('{0, 0, 1, 1, 1, 1, 0,  1, 1, 0, 0, 0, 1, 0});
        tv.push_back('{0, 0, 1, 1, 1, 1, 0,  1, 0, 1, 0, 1, 1, 0});
        tv.push_back('{0, 0, 1, 1, 1, 1, 1,  1, 0, 0, 0, 0, 1, 0});
        tv.push_back('{0, 0, 1, 1, 1, 1, 0,  1, 0, 0, 0, 0, 0, 0});
        // AWLEN=3 with data ready toggling
        tv.push_back('{1, 3, 1, 0, 1, 1, 0,  1, 0, 0, 0, 0, 0, 0});
        tv.push_back('{0, 3, 1, 0, 1, 1, 0,  1, 0, 0, 0, 0, 1, 0});
        tv.push_back('{0, 3, 1, 0, 1, 1, 0,  1, 1, 0, 0, 0, 1, 0});
        tv.push_back('{0, 3, 1, 0, 1, 1, 0,  1, 0, 1, 0, 0, 1, 0});
        tv.push_back('{0, 3, 1, 0, 1, 0, 0,  1, 0, 1, 1, 0, 1, 0});
        tv.push_back('{0, 3, 1, 0, 1, 1, 0,  1, 0, 1, 1, 0, 1, 0});
        tv.push_back('{0, 3, 1, 0, 1, 0, 0,  1, 0, 1, 2, 0, 1, 0});
        tv.push_back('{0, 3, 1, 0, 1, 1, 0,  1, 0, 1, 2, 0, 1, 0});
        tv.push_back('{0, 3, 1, 1, 1, 0, 0,  1, 0, 1, 3, 1, 1, 0});
        tv.push_back('{0, 3, 1, 1, 1, 1, 0,  1, 0, 1, 3, 1, 1, 0});
        tv.push_back('{0, 3, 1, 1, 1, 1, 1,  1, 0, 0, 0, 0, 1, 0});
        tv.push_back('{0, 3, 1, 1, 1, 1, 0,  1, 0, 0, 0, 0, 0, 0});
        // AWLEN=1 with early WLAST: sticky error, burst still two beats
        tv.push_back('{1, 1, 1, 1, 1, 1, 0,  1, 0, 0, 0, 0, 0, 0});
        tv.push_back('{0, 1, 1, 1, 1, 1, 0,  1, 0, 0, 0, 0, 1, 0});
        tv.push_back('{0, 1, 1, 1, 1, 1, 0,  1, 1, 0, 0, 0, 1, 0});
        tv.push_back('{0, 1, 1, 1, 1, 1, 0,  1, 0, 1, 0, 0, 1, 0});
        tv.push_back('{0, 1, 1, 1, 1, 1, 0,  1, 0, 1, 1, 1, 1, 1});
        tv.push_back('{0, 1, 1, 1, 1, 1, 1,  1, 0, 0, 0, 0, 1, 1});
        tv.push_back('{0, 1, 1, 1, 1, 1, 0,  1, 0, 0, 0, 0, 0, 1});

        do_reset();
        for (int i = 0; i < tv.size(); i++) begin
            @(posedge clk); #1;
            awvalid = tv[i].awv; aw_ch = mk_aw(tv[i].len, 32'h4000_0000 + i);
            wvalid = tv[i].wv; w_ch = mk_w(tv[i].wl, 32'h1234_0000 + i);
            req_ready = tv[i].rqr; dat_ready = tv[i].dr; b_done = tv[i].bd;
            #1;
            chk($sformatf("tv%0d_awready", i), awready, tv[i].e_awr);
            chk($sformatf("tv%0d_req_valid", i), req_valid, tv[i].e_rqv);
            chk($sformatf("tv%0d_dat_valid", i), dat_valid, tv[i].e_dat && tv[i].wv);
            chk($sformatf("tv%0d_wready", i), wready, tv[i].e_dat && tv[i].dr);
            chk($sformatf("tv%0d_os", i), os_cnt, tv[i].e_os);
            chk($sformatf("tv%0d_err", i), err_wlast, tv[i].e_err);
            if (tv[i].e_dat) begin
                chk($sformatf("tv%0d_idx", i), dat_idx, tv[i].e_idx);
                chk($sformatf("tv%0d_last", i), dat_last, tv[i].e_last);
            end
        end

        // Outstanding cap: eight writes with no completions
        do_reset();
        req_ready = 1; dat_ready = 1; wvalid = 1; w_ch = mk_w(1'b1, 32'hcafe);
        n_hs = 0;
        for (int c = 0; c < 60 && n_hs < 8; c++) begin
            @(posedge clk); #1;
            awvalid = 1; aw_ch = mk_aw(8'd0, 32'h3000_0000 + c);
            #1;
            if (awready) n_hs++;
        end
        chk("os_hs_count", n_hs, 8);
        @(posedge clk); #1; awvalid = 0; #1;
        chk("os_cap_count", os_cnt, 8);
        chk("os_cap_awready", awready, 0);
        repeat (20) @(posedge clk);
        #2;
        chk("os_drained_awready", awready, 0);
        chk("os_drained_req_valid", req_valid, 0);
        @(posedge clk); #1; b_done = 1; #1;
        chk("os_bdone_cycle_awready", awready, 0);
        @(posedge clk); #1; b_done = 0; #1;
        chk("os_reopen_awready", awready, 1);
        chk("os_reopen_count", os_cnt, 7);
        @(posedge clk); #1; awvalid = 1; aw_ch = mk_aw(8'd0, 32'h3100_0000); b_done = 1; #1;
        @(posedge clk); #1; awvalid = 0; b_done = 0; #1;
        chk("os_simul_unchanged", os_cnt, 7);
        @(posedge clk); #1; awvalid = 1; aw_ch = mk_aw(8'd0, 32'h3200_0000); #1;
        @(posedge clk); #1; awvalid = 0; #1;
        chk("os_refill_count", os_cnt, 8);
        chk("os_refill_awready", awready, 0);

        // FIFO full with the core request stalled
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            awvalid = 1; aw_ch = mk_aw(8'(i), 32'h2000_0000 + i);
            #1;
            chk($sformatf("full_fill%0d_awready", i), awready, 1);
        end
        @(posedge clk); #1; aw_ch = mk_aw(8'd0, 32'hdead_0000); #1;
        chk("full_awready", awready, 0);
        chk("full_os", os_cnt, 4);
        chk("full_req_aw_head", req_aw, mk_aw(8'd0, 32'h2000_0000));
        @(posedge clk); #1; awvalid = 0; req_ready = 1; #1;
        chk("full_no_push_os", os_cnt, 4);
        @(posedge clk); #1; req_ready = 0; wvalid = 1; dat_ready = 1; w_ch = mk_w(1'b1, 32'h77); #1;
        chk("full_pop_beat_last", dat_last, 1);
        chk("full_pop_cycle_awready", awready, 0);
        @(posedge clk); #1; wvalid = 0; #1;
        chk("full_after_pop_awready", awready, 1);
        chk("full_next_req_aw", req_aw, mk_aw(8'd1, 32'h2000_0001));

        // Asynchronous reset during beat 2 of an AWLEN=7 burst
        do_reset();
        req_ready = 1; dat_ready = 1; wvalid = 1; w_ch = mk_w(1'b0, 32'hbeef);
        @(posedge clk); #1; awvalid = 1; aw_ch = mk_aw(8'd7, 32'h5000_0000); #1;
        @(posedge clk); #1; awvalid = 0;
        repeat (4) @(posedge clk);
        #2;
        chk("rstmid_idx_before", dat_idx, 2);
        rst_n = 1'b0;
        #1;
        chk("rstmid_dat_valid", dat_valid, 0);
        chk("rstmid_wready", wready, 0);
        chk("rstmid_awready", awready, 0);
        chk("rstmid_req_valid", req_valid, 0);
        chk("rstmid_os", os_cnt, 0);
        chk("rstmid_idx", dat_idx, 0);
        do_reset();
        req_ready = 1; dat_ready = 1; wvalid = 1; w_ch = mk_w(1'b1, 32'h600d);
        @(posedge clk); #1; awvalid = 1; aw_ch = mk_aw(8'd0, 32'h5100_0000); #1;
        @(posedge clk); #1; awvalid = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("rstmid_new_dat_valid", dat_valid, 1);
        chk("rstmid_new_idx", dat_idx, 0);
        chk("rstmid_new_last", dat_last, 1);

        // Randomized traffic against the queue model
        do_reset();
        mq.delete(); m_os = 0; m_beat = 0; m_req = 0; m_dat = 0; m_err = 0;
        for (int c = 0; c < 4000 && n_err < 100; c++) begin
            @(posedge clk); #1;
            hl = (mq.size() > 0) ? mq[0][`AXI4_AWLEN_RANGE] : 8'd0;
            m_last = m_dat && (m_beat == int'(hl));
            awvalid   = ($urandom % 2) == 0;
            aw_ch     = mk_aw((($urandom % 16) == 0) ? 8'd255 : 8'($urandom % 4), $urandom);
            wvalid    = ($urandom % 4) != 0;
            dat_ready = ($urandom % 4) != 0;
            req_ready = ($urandom % 2) == 0;
            b_done    = ($urandom % 4) == 0;
            w_ch      = mk_w((m_dat ? m_last : 1'($urandom % 2)) ^ (($urandom % 32) == 0), $urandom);
            #1;
            e_awr = (mq.size() < 4) && (m_os < 8);
            chk("rnd_awready", awready, e_awr);
            chk("rnd_req_valid", req_valid, m_req);
            chk("rnd_dat_valid", dat_valid, m_dat && wvalid);
            chk("rnd_wready", wready, m_dat && dat_ready);
            chk("rnd_os", os_cnt, m_os);
            chk("rnd_err", err_wlast, m_err);
            if (m_req) chk("rnd_req_aw", req_aw, mq[0]);
            if (m_dat) begin
                chk("rnd_idx", dat_idx, m_beat);
                chk("rnd_last", dat_last, m_last);
                chk("rnd_w", dat_w, w_ch);
            end
            aw_hs  = awvalid && e_awr;
            old_sz = mq.size();
            if (m_req) begin
                if (req_ready) begin
                    m_req = 0; m_dat = 1; m_beat = 0;
                end
            end else if (m_dat) begin
                if (wvalid && dat_ready) begin
                    if (w_ch[`AXI4_WLAST_RANGE] != m_last) m_err = 1;
                    if (m_last) begin
                        void'(mq.pop_front());
                        m_dat = 0;
                        m_req = (old_sz - 1 + int'(aw_hs)) > 0;
                    end else begin
                        m_beat++;
                    end
                end
            end else if (old_sz > 0) begin
                m_req = 1;
            end
            if (aw_hs) mq.push_back(aw_ch);
            if (aw_hs && !(b_done && m_os > 0)) m_os++;
            else if (!aw_hs && b_done && m_os > 0) m_os--;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
